// File: rtl/serial_add_sched_if.sv
// Request/response bundle between two client requesters and the
// bit-serial add scheduler.
interface serial_add_sched_if #(
  parameter int W = 8
);
  logic         req0_valid;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;
  logic         req0_ready;

  logic         req1_valid;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;
  logic         req1_ready;

  logic         busy;
  logic         rsp_valid;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;

  // Client side: issues requests and consumes responses.
  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req0_ready, req1_ready,
    input  busy, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req0_ready, req1_ready,
    output busy, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one 1-bit full-adder cell between two
// requesters; W-bit sums are formed LSB first over W cycles.
module serial_add_sched #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_sched_if.slave bus
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_nextState;

  logic [W-1:0]   r_shA;
  logic [W-1:0]   r_shB;
  logic [W-1:0]   r_sumSh;
  logic           r_carry;
  logic [CW-1:0]  r_cnt;
  logic           r_owner;
  logic           r_last;

  logic [W-1:0]   r_rspSum;
  logic           r_rspCout;
  logic           r_rspId;

  logic           w_s;
  logic           w_co;
  logic [W-1:0]   w_sumNext;
  logic           w_grantValid;
  logic           w_grantId;
  logic           w_ready0;
  logic           w_ready1;

  // The single shared full-adder cell.
  assign w_s  = r_shA[0] ^ r_shB[0] ^ r_carry;
  assign w_co = (r_shA[0] & r_shB[0]) | (r_carry & (r_shA[0] ^ r_shB[0]));

  generate
    if (W == 1) begin : gSumOne
      assign w_sumNext = w_s;
    end else begin : gSumWide
      assign w_sumNext = {w_s, r_sumSh[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Tie between requesters goes to whichever was not granted last.
  always_comb begin
    w_nextState  = r_state;
    w_grantValid = 1'b0;
    w_grantId    = 1'b0;
    w_ready0     = 1'b0;
    w_ready1     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst) begin
          if (bus.req0_valid && bus.req1_valid) begin
            w_grantValid = 1'b1;
            w_grantId    = ~r_last;
          end else if (bus.req0_valid) begin
            w_grantValid = 1'b1;
            w_grantId    = 1'b0;
          end else if (bus.req1_valid) begin
            w_grantValid = 1'b1;
            w_grantId    = 1'b1;
          end
          w_ready0 = w_grantValid && !w_grantId;
          w_ready1 = w_grantValid && w_grantId;
          if (w_grantValid) begin
            w_nextState = ADD;
          end
        end
      end
      ADD: begin
        if (r_cnt == LAST_CNT) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shA     <= '0;
      r_shB     <= '0;
      r_sumSh   <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_rspSum  <= '0;
      r_rspCout <= 1'b0;
      r_rspId   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_shA   <= w_grantId ? bus.req1_a   : bus.req0_a;
            r_shB   <= w_grantId ? bus.req1_b   : bus.req0_b;
            r_carry <= w_grantId ? bus.req1_cin : bus.req0_cin;
            r_owner <= w_grantId;
            r_last  <= w_grantId;
            r_cnt   <= '0;
          end
        end
        ADD: begin
          r_sumSh <= w_sumNext;
          r_shA   <= r_shA >> 1;
          r_shB   <= r_shB >> 1;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
        end
        DONE: begin
          r_rspSum  <= r_sumSh;
          r_rspCout <= r_carry;
          r_rspId   <= r_owner;
        end
        default: begin
        end
      endcase
    end
  end

  // Response fields come straight from the working registers in DONE and
  // from the held copies otherwise, so they stay stable between pulses.
  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.busy       = (r_state != IDLE);
  assign bus.rsp_valid  = (r_state == DONE);
  assign bus.rsp_sum    = (r_state == DONE) ? r_sumSh : r_rspSum;
  assign bus.rsp_cout   = (r_state == DONE) ? r_carry : r_rspCout;
  assign bus.rsp_id     = (r_state == DONE) ? r_owner : r_rspId;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed self-checking bench for serial_add_sched (W=8 and W=1 instances).
module tb_serial_add_sched;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  serial_add_sched_if #(.W(8)) bus8 ();
  serial_add_sched_if #(.W(1)) bus1 ();

  serial_add_sched #(.W(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  serial_add_sched #(.W(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                               input logic c0, input logic v1, input logic [7:0] a1,
                               input logic [7:0] b1, input logic c1);
    bus8.req0_valid = v0;
    bus8.req0_a     = a0;
    bus8.req0_b     = b0;
    bus8.req0_cin   = c0;
    bus8.req1_valid = v1;
    bus8.req1_a     = a1;
    bus8.req1_b     = b1;
    bus8.req1_cin   = c1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a transfer edge; returns at the negedge of the DONE cycle.
  task automatic waitRsp(input string tag, input int expLat, input logic expId,
                         input logic [7:0] expSum, input logic expCout);
    int lat = 0;
    int rdy = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus8.req0_ready || bus8.req1_ready) rdy++;
      if (bus8.rsp_valid) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_readyWhileBusy"}, rdy, 0);
    checkOutput({tag, "_id"}, bus8.rsp_id, expId);
    checkOutput({tag, "_sum"}, bus8.rsp_sum, expSum);
    checkOutput({tag, "_cout"}, bus8.rsp_cout, expCout);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] a0;
    logic [7:0] a1;
    logic       v0;
    logic       v1;
    int         lat;
    int         cnt;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    bus1.req0_valid = 1'b0;
    bus1.req0_a     = 1'b0;
    bus1.req0_b     = 1'b0;
    bus1.req0_cin   = 1'b0;
    bus1.req1_valid = 1'b0;
    bus1.req1_a     = 1'b0;
    bus1.req1_b     = 1'b0;
    bus1.req1_cin   = 1'b0;

    // Reset state of both instances
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_busy", bus8.busy, 0);
    checkOutput("rst_rspValid", bus8.rsp_valid, 0);
    checkOutput("rst_rspId", bus8.rsp_id, 0);
    checkOutput("rst_rspSum", bus8.rsp_sum, 0);
    checkOutput("rst_rspCout", bus8.rsp_cout, 0);
    checkOutput("rst_w1_rspSum", bus1.rsp_sum, 0);
    nextCycle();
    rst = 1'b0;

    // Requester 0 alone: 0x5A + 0x3C
    applyStimulus(1, 8'h5A, 8'h3C, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    checkOutput("t1_ready0", bus8.req0_ready, 1);
    checkOutput("t1_ready1", bus8.req1_ready, 0);
    nextCycle();
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    waitRsp("t1", 9, 0, 8'h96, 0);
    checkOutput("t1_busyInDone", bus8.busy, 1);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_pulseEnds", bus8.rsp_valid, 0);
    checkOutput("t1_sumHeld", bus8.rsp_sum, 8'h96);
    checkOutput("t1_idleBusy", bus8.busy, 0);

    // Requester 1 alone: 0xFF + 0x01 + 1
    nextCycle();
    applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hFF, 8'h01, 1);
    @(negedge clk);
    checkOutput("t2_ready0", bus8.req0_ready, 0);
    checkOutput("t2_ready1", bus8.req1_ready, 1);
    nextCycle();
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    waitRsp("t2", 9, 1, 8'h01, 1);
    nextCycle();

    // Both valid from reset: 4 ops each, grants must alternate 0,1,0,1...
    rst = 1'b1;
    v0 = 1; v1 = 1; a0 = 8'd1; a1 = 8'd1;
    applyStimulus(v0, a0, a0, 0, v1, a1, a1, 0);
    @(negedge clk);
    checkOutput("t3_rstReady0", bus8.req0_ready, 0);
    checkOutput("t3_rstReady1", bus8.req1_ready, 0);
    nextCycle();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] opVal;
      opVal = 8'(k / 2 + 1);
      @(negedge clk);
      checkOutput($sformatf("t3_op%0d_ready0", k), bus8.req0_ready, (k % 2 == 0));
      checkOutput($sformatf("t3_op%0d_ready1", k), bus8.req1_ready, (k % 2 == 1));
      nextCycle();
      if (k % 2 == 0) begin
        if (opVal < 8'd4) a0 = opVal + 8'd1;
        else v0 = 0;
      end else begin
        if (opVal < 8'd4) a1 = opVal + 8'd1;
        else v1 = 0;
      end
      applyStimulus(v0, a0, a0, 0, v1, a1, a1, 0);
      waitRsp($sformatf("t3_op%0d", k), 9, 1'(k % 2), 8'(2 * opVal), 0);
      nextCycle();
    end

    // req1 arrives while busy and changes its operands while waiting
    applyStimulus(1, 8'h10, 8'h20, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    checkOutput("t4_ready0", bus8.req0_ready, 1);
    nextCycle();
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    lat = 0;
    cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 3) applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h11, 8'h22, 0);
      if (n == 6) applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h80, 8'h90, 1);
      @(negedge clk);
      if (bus8.req1_ready) cnt++;
      if (bus8.rsp_valid) begin
        lat = n;
        break;
      end
      nextCycle();
    end
    checkOutput("t4a_latency", lat, 9);
    checkOutput("t4_ready1WhileBusy", cnt, 0);
    checkOutput("t4a_sum", bus8.rsp_sum, 8'h30);
    checkOutput("t4a_id", bus8.rsp_id, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t4_ready1FirstIdle", bus8.req1_ready, 1);
    nextCycle();
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'hFF, 8'hFF, 0);
    waitRsp("t4b", 9, 1, 8'h11, 1);
    nextCycle();

    // Reset in the 4th ADD cycle; afterwards requester 0 must win a tie
    applyStimulus(1, 8'h01, 8'h02, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk);
    checkOutput("t5_ready0", bus8.req0_ready, 1);
    nextCycle();
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    nextCycle();
    nextCycle();
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_busyBeforeRst", bus8.busy, 1);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_busy", bus8.busy, 0);
    checkOutput("t5_rspValid", bus8.rsp_valid, 0);
    checkOutput("t5_rspId", bus8.rsp_id, 0);
    checkOutput("t5_rspSum", bus8.rsp_sum, 0);
    checkOutput("t5_rspCout", bus8.rsp_cout, 0);
    checkOutput("t5_ready0", bus8.req0_ready, 0);
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      nextCycle();
      @(negedge clk);
      if (bus8.rsp_valid) cnt++;
    end
    checkOutput("t5_noResponse", cnt, 0);
    nextCycle();
    applyStimulus(1, 8'h40, 8'h40, 0, 1, 8'h0F, 8'hF1, 0);
    @(negedge clk);
    checkOutput("t5_tieReady0", bus8.req0_ready, 1);
    checkOutput("t5_tieReady1", bus8.req1_ready, 0);
    nextCycle();
    applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'h0F, 8'hF1, 0);
    waitRsp("t5a", 9, 0, 8'h80, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("t5_nextReady1", bus8.req1_ready, 1);
    nextCycle();
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    waitRsp("t5b", 9, 1, 8'h00, 1);
    nextCycle();

    // W=1 instance: 1 + 1 + 1
    bus1.req0_valid = 1'b1;
    bus1.req0_a     = 1'b1;
    bus1.req0_b     = 1'b1;
    bus1.req0_cin   = 1'b1;
    @(negedge clk);
    checkOutput("t6_ready0", bus1.req0_ready, 1);
    nextCycle();
    bus1.req0_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus1.rsp_valid) begin
        lat = n;
        break;
      end
      nextCycle();
    end
    checkOutput("t6_latency", lat, 2);
    checkOutput("t6_sum", bus1.rsp_sum, 1);
    checkOutput("t6_cout", bus1.rsp_cout, 1);
    checkOutput("t6_id", bus1.rsp_id, 0);
    nextCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
